// File: rtl/scan_adder_pkg.sv
// scan_adder_pkg: shared sizing helpers and cell index map for scan_adder.
// All scan cell positions are derived from these functions.
package scan_adder_pkg;

    // Field selector for a scan cell index.
    typedef enum logic [2:0] {
        FLD_A,
        FLD_B,
        FLD_CIN,
        FLD_SUM,
        FLD_COUT
    } field_e;

    localparam int A_BASE = 0;

    // Total number of scan cells for a given operand width.
    function automatic int chain_len(input int width);
        return 3 * width + 2;
    endfunction

    // Longest chain length once the cells are spread over num_chains.
    function automatic int seg_len(input int width, input int num_chains);
        return (chain_len(width) + num_chains - 1) / num_chains;
    endfunction

    function automatic int b_base(input int width);
        return width;
    endfunction

    function automatic int cin_base(input int width);
        return 2 * width;
    endfunction

    function automatic int sum_base(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int cout_base(input int width);
        return 3 * width + 1;
    endfunction

    // Which field a given cell index belongs to.
    function automatic field_e cell_field(input int idx, input int width);
        if (idx < b_base(width))
            return FLD_A;
        else if (idx < cin_base(width))
            return FLD_B;
        else if (idx == cin_base(width))
            return FLD_CIN;
        else if (idx < cout_base(width))
            return FLD_SUM;
        else
            return FLD_COUT;
    endfunction

endpackage

// File: rtl/scan_adder_cell.sv
// scan_cell: one mux-D scan flop.
// scan_en selects the serial input over the functional input.
module scan_cell (
    input  logic clk,
    input  logic rst,
    input  logic scan_en,
    input  logic d,
    input  logic si,
    output logic q
);

    // Shift from si in scan mode, capture d otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 1'b0;
        else
            q <= scan_en ? si : d;
    end

endmodule

// File: rtl/scan_adder.sv
// scan_adder: registered ripple adder wrapped in interleaved scan chains.
// Cells are indexed by the package map; chain c owns indices c mod N.
module scan_adder
    import scan_adder_pkg::*;
#(
    parameter  int WIDTH      = 4,
    parameter  int NUM_CHAINS = 1,
    localparam int L          = chain_len(WIDTH),
    localparam int SEG        = seg_len(WIDTH, NUM_CHAINS),
    localparam int CW         = $clog2(SEG + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      a_in,
    input  logic [WIDTH-1:0]      b_in,
    input  logic                  cin_in,
    input  logic                  scan_en,
    input  logic [NUM_CHAINS-1:0] scan_in,
    output logic [NUM_CHAINS-1:0] scan_out,
    output logic [WIDTH-1:0]      sum,
    output logic                  cout,
    output logic [CW-1:0]         shift_cnt,
    output logic                  seg_done
);

    localparam int B0    = b_base(WIDTH);
    localparam int CIN0  = cin_base(WIDTH);
    localparam int SUM0  = sum_base(WIDTH);
    localparam int COUT0 = cout_base(WIDTH);

    localparam logic [CW-1:0] SEG_C = CW'(SEG);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [L-1:0]     q;
    logic [L-1:0]     d;
    logic [L-1:0]     si;
    logic [WIDTH:0]   result;
    logic [CW-1:0]    cnt_next;

    // Full-width add of the registered operands; carry lands in result[WIDTH].
    assign result = {1'b0, q[A_BASE +: WIDTH]}
                  + {1'b0, q[B0 +: WIDTH]}
                  + {{WIDTH{1'b0}}, q[CIN0]};

    // Functional next-state, laid out in cell index order.
    assign d = {result[WIDTH], result[WIDTH-1:0], cin_in, b_in, a_in};

    assign sum  = q[SUM0 +: WIDTH];
    assign cout = q[COUT0];

    genvar i;
    generate
        for (i = 0; i < L; i++) begin : g_cell
            if (i < NUM_CHAINS) begin : g_head
                assign si[i] = scan_in[i];
            end else begin : g_link
                assign si[i] = q[i-NUM_CHAINS];
            end

            scan_cell u_cell (
                .clk     (clk),
                .rst     (rst),
                .scan_en (scan_en),
                .d       (d[i]),
                .si      (si[i]),
                .q       (q[i])
            );
        end

        for (i = 0; i < NUM_CHAINS; i++) begin : g_tail
            localparam int LAST = i + NUM_CHAINS * ((L - 1 - i) / NUM_CHAINS);
            assign scan_out[i] = q[LAST];
        end
    endgenerate

    // Next shift count: 1..SEG repeating while shifting, 0 otherwise.
    always_comb begin
        cnt_next = '0;
        if (scan_en)
            cnt_next = (shift_cnt == SEG_C) ? ONE_C : shift_cnt + ONE_C;
    end

    // Shift counter and the one-cycle segment-complete pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_cnt <= '0;
            seg_done  <= 1'b0;
        end else begin
            shift_cnt <= cnt_next;
            seg_done  <= (cnt_next == SEG_C);
        end
    end

endmodule

// File: tb/tb_scan_adder.sv
// tb_scan_adder: checks two scan_adder configurations (1 and 3 chains)
// against a behavioural cell-vector model plus fixed vectors.
module tb_scan_adder;

    localparam int W  = 4;
    localparam int L  = 14;
    localparam int S1 = 14;
    localparam int S3 = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         scan_en;
    logic [0:0]   si1;
    logic [2:0]   si3;

    logic [0:0]   so1;
    logic [W-1:0] sum1;
    logic         cout1;
    logic [3:0]   cnt1;
    logic         done1;

    logic [2:0]   so3;
    logic [W-1:0] sum3;
    logic         cout3;
    logic [2:0]   cnt3;
    logic         done3;

    always #5 clk = ~clk;

    scan_adder #(.WIDTH(W), .NUM_CHAINS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .scan_en   (scan_en),
        .scan_in   (si1),
        .scan_out  (so1),
        .sum       (sum1),
        .cout      (cout1),
        .shift_cnt (cnt1),
        .seg_done  (done1)
    );

    scan_adder #(.WIDTH(W), .NUM_CHAINS(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .scan_en   (scan_en),
        .scan_in   (si3),
        .scan_out  (so3),
        .sum       (sum3),
        .cout      (cout3),
        .shift_cnt (cnt3),
        .seg_done  (done3)
    );

    int errors = 0;
    int checks = 0;

    // Model state: cell vector per DUT and count of consecutive shift edges.
    logic [L-1:0] m1;
    logic [L-1:0] m3;
    int           k;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t tbl[3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [L-1:0] nxt(input logic [L-1:0] m, input int nc,
                                         input logic [2:0] si, input logic en,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c);
        logic [L-1:0] r;
        logic         p;
        int           s;
        r = m;
        if (!en) begin
            s = int'(m[3:0]) + int'(m[7:4]) + int'(m[8]);
            r[3:0]  = a;
            r[7:4]  = b;
            r[8]    = c;
            r[12:9] = s[3:0];
            r[13]   = s[4];
        end else begin
            for (int ch = 0; ch < nc; ch++) begin
                p = si[ch];
                for (int i = ch; i < L; i += nc) begin
                    r[i] = p;
                    p = m[i];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] so_exp(input logic [L-1:0] m, input int nc);
        logic [2:0] r;
        int         last;
        r = '0;
        for (int ch = 0; ch < nc; ch++) begin
            last = ch;
            for (int i = ch; i < L; i += nc)
                last = i;
            r[ch] = m[last];
        end
        return r;
    endfunction

    function automatic int cnt_exp(input int kk, input int seg);
        return (kk == 0) ? 0 : ((kk - 1) % seg) + 1;
    endfunction

    function automatic int done_exp(input int kk, input int seg);
        return (kk > 0 && kk % seg == 0) ? 1 : 0;
    endfunction

    task automatic check_all();
        logic [2:0] e1;
        logic [2:0] e3;
        e1 = so_exp(m1, 1);
        e3 = so_exp(m3, 3);
        chk("sum1",  32'(sum1),  32'(m1[12:9]));
        chk("cout1", 32'(cout1), 32'(m1[13]));
        chk("so1",   32'(so1),   32'(e1[0]));
        chk("cnt1",  32'(cnt1),  32'(cnt_exp(k, S1)));
        chk("done1", 32'(done1), 32'(done_exp(k, S1)));
        chk("sum3",  32'(sum3),  32'(m3[12:9]));
        chk("cout3", 32'(cout3), 32'(m3[13]));
        chk("so3",   32'(so3),   32'(e3));
        chk("cnt3",  32'(cnt3),  32'(cnt_exp(k, S3)));
        chk("done3", 32'(done3), 32'(done_exp(k, S3)));
    endtask

    task automatic tick();
        @(posedge clk);
        m1 = nxt(m1, 1, {2'b00, si1}, scan_en, a_in, b_in, cin_in);
        m3 = nxt(m3, 3, si3, scan_en, a_in, b_in, cin_in);
        k  = scan_en ? k + 1 : 0;
        @(negedge clk);
        check_all();
    endtask

    logic [L-1:0] v;
    logic [L-1:0] got;
    logic [L-1:0] ex;
    logic         in1[28];
    logic         out1[28];
    logic [2:0]   in3[28];
    logic [2:0]   out3[28];
    int           pulses1;
    int           pulses3;
    int           idx;
    int           len;

    initial begin
        tbl[0] = '{a: 4'd3,  b: 4'd5,  c: 1'b0, s: 4'd8,  co: 1'b0};
        tbl[1] = '{a: 4'd15, b: 4'd15, c: 1'b1, s: 4'd15, co: 1'b1};
        tbl[2] = '{a: 4'd9,  b: 4'd6,  c: 1'b1, s: 4'd0,  co: 1'b1};

        rst     = 1'b1;
        a_in    = '0;
        b_in    = '0;
        cin_in  = 1'b0;
        scan_en = 1'b0;
        si1     = '0;
        si3     = '0;
        m1      = '0;
        m3      = '0;
        k       = 0;

        // Reset state.
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Functional vectors from the table, two-cycle latency.
        for (int j = 0; j < 4; j++) begin
            if (j < 3) begin
                a_in   = tbl[j].a;
                b_in   = tbl[j].b;
                cin_in = tbl[j].c;
            end else begin
                a_in   = '0;
                b_in   = '0;
                cin_in = 1'b0;
            end
            tick();
            if (j >= 1) begin
                chk("tbl_sum1",  32'(sum1),  32'(tbl[j-1].s));
                chk("tbl_cout1", 32'(cout1), 32'(tbl[j-1].co));
                chk("tbl_sum3",  32'(sum3),  32'(tbl[j-1].s));
                chk("tbl_cout3", 32'(cout3), 32'(tbl[j-1].co));
            end
        end

        // Random mix of capture and shift cycles.
        for (int j = 0; j < 60; j++) begin
            a_in    = W'($urandom);
            b_in    = W'($urandom);
            cin_in  = 1'($urandom);
            scan_en = ($urandom_range(0, 3) == 0);
            si1     = 1'($urandom);
            si3     = 3'($urandom);
            tick();
        end

        // Reset asserted mid-shift at shift_cnt=5.
        scan_en = 1'b0;
        tick();
        scan_en = 1'b1;
        for (int j = 0; j < 5; j++) begin
            si1 = 1'($urandom);
            si3 = 3'($urandom);
            tick();
        end
        chk("cnt_pre_rst", 32'(cnt1), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_sum1",  32'(sum1),  32'd0);
        chk("rst_cout1", 32'(cout1), 32'd0);
        chk("rst_so1",   32'(so1),   32'd0);
        chk("rst_cnt1",  32'(cnt1),  32'd0);
        chk("rst_so3",   32'(so3),   32'd0);
        chk("rst_cnt3",  32'(cnt3),  32'd0);
        m1 = '0;
        m3 = '0;
        k  = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("cnt_after_rst", 32'(cnt1), 32'd1);

        // Single chain: load a=3 b=5 cin=1, capture, unload.
        scan_en = 1'b0;
        tick();
        v = {1'b0, 4'd0, 1'b1, 4'd5, 4'd3};
        scan_en = 1'b1;
        for (int j = 0; j < S1; j++) begin
            si1 = v[S1-1-j];
            si3 = 3'($urandom);
            tick();
            if (j == S1 - 2)
                chk("load_done_early", 32'(done1), 32'd0);
            if (j == S1 - 1)
                chk("load_done", 32'(done1), 32'd1);
        end
        scan_en = 1'b0;
        a_in    = '0;
        b_in    = '0;
        cin_in  = 1'b0;
        tick();
        chk("cap_sum", 32'(sum1), 32'd9);
        chk("cap_cout", 32'(cout1), 32'd0);
        ex = 14'b0_1001_0_0000_0000;
        scan_en = 1'b1;
        for (int j = 0; j < S1; j++) begin
            chk("unload_bit", 32'(so1), 32'(ex[S1-1-j]));
            si1 = '0;
            tick();
        end

        // Three chains: load a random cell vector, unload and rebuild it.
        scan_en = 1'b0;
        tick();
        v = L'($urandom);
        scan_en = 1'b1;
        for (int j = 0; j < S3; j++) begin
            for (int ch = 0; ch < 3; ch++) begin
                idx = ch + 3 * (S3 - 1 - j);
                si3[ch] = (idx < L) ? v[idx] : 1'($urandom);
            end
            tick();
        end
        chk("c3_done", 32'(done3), 32'd1);
        chk("c3_cnt",  32'(cnt3),  32'd5);
        got = '0;
        for (int j = 0; j < S3; j++) begin
            for (int ch = 0; ch < 3; ch++) begin
                len = (L - ch + 2) / 3;
                if (j < len)
                    got[ch + 3 * (len - 1 - j)] = so3[ch];
            end
            si3 = '0;
            tick();
        end
        chk("c3_unload", 32'(got), 32'(v));

        // Mode drop mid-segment clears the counters.
        scan_en = 1'b0;
        tick();
        scan_en = 1'b1;
        tick();
        tick();
        tick();
        scan_en = 1'b0;
        tick();
        chk("drop_cnt1", 32'(cnt1), 32'd0);
        chk("drop_cnt3", 32'(cnt3), 32'd0);
        scan_en = 1'b1;
        tick();
        chk("resume_cnt3", 32'(cnt3), 32'd1);

        // Identity stream with scan_en held for 2*SEG of the long chain.
        scan_en = 1'b0;
        tick();
        scan_en = 1'b1;
        pulses1 = 0;
        pulses3 = 0;
        for (int t = 0; t < 2 * S1; t++) begin
            si1 = 1'($urandom);
            si3 = 3'($urandom);
            in1[t]  = si1[0];
            in3[t]  = si3;
            out1[t] = so1[0];
            out3[t] = so3;
            tick();
            if (done1)
                pulses1++;
            if (done3 && t < 2 * S3)
                pulses3++;
        end
        chk("pulses1", 32'(pulses1), 32'd2);
        chk("pulses3", 32'(pulses3), 32'd2);
        for (int t = S1; t < 2 * S1; t++)
            chk("ident1", 32'(out1[t]), 32'(in1[t-S1]));
        for (int ch = 0; ch < 3; ch++) begin
            len = (L - ch + 2) / 3;
            for (int t = len; t < 2 * S1; t++)
                chk("ident3", 32'(out3[t][ch]), 32'(in3[t-len][ch]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
